// File: rtl/uart_word_packer.sv
// uart_word_packer: drains the UART RX byte FIFO, packs bytes little-endian
// into 32-bit words and hands them, with address and byte strobes, to the
// downstream write path. Partial words leave on idle timeout or flush.
module uart_word_packer #(
    parameter int unsigned           DATA_WIDTH     = 8,
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int unsigned           TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_r_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  flush,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic [31:0]           word_data,
    output logic [3:0]            word_strb,
    output logic [ADDR_WIDTH-1:0] word_addr,
    output logic                  busy
);

    // A zero timeout still needs a 1-bit counter so the declarations stay legal.
    localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        EMIT  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic [31:0]           data_q, data_d;
    logic [3:0]            strb_q, strb_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rd_en;
    logic                  timeout_hit;

    // State registers; reset discards any pending word and any popped byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            cnt_q   <= '0;
            idle_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            addr_q  <= BASE_ADDR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state logic: read sequencing, byte capture, idle timing and word handoff.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idle_d      = idle_q;
        data_d      = data_q;
        strb_d      = strb_q;
        addr_d      = addr_q;
        rd_en       = 1'b0;
        timeout_hit = TIMEOUT_EN && (idle_q == IDLE_MAX);

        case (state_q)
            FETCH: begin
                if (cnt_q != 3'd0 && (flush || timeout_hit)) begin
                    // Flush/timeout outrank a new read so a stalled partial word leaves promptly.
                    state_d = EMIT;
                end else if (cnt_q < 3'd4 && !fifo_empty) begin
                    rd_en   = 1'b1;
                    state_d = WAIT;
                end else if (cnt_q != 3'd0 && fifo_empty && TIMEOUT_EN && idle_q != IDLE_MAX) begin
                    idle_d = idle_q + 1'b1;
                end
                if (cnt_q == 3'd0) begin
                    idle_d = '0;
                end
            end
            WAIT: begin
                data_d[{cnt_q[1:0], 3'b000} +: 8] = fifo_data;
                strb_d[cnt_q[1:0]]                = 1'b1;
                cnt_d                             = cnt_q + 3'd1;
                idle_d                            = '0;
                state_d                           = (cnt_q == 3'd3) ? EMIT : FETCH;
            end
            EMIT: begin
                if (word_ready) begin
                    addr_d  = addr_q + ADDR_WIDTH'(4);
                    data_d  = '0;
                    strb_d  = '0;
                    cnt_d   = '0;
                    idle_d  = '0;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // The read strobe is masked during reset so no byte is popped and then dropped.
    assign fifo_r_en  = rd_en & ~rst;
    assign word_valid = (state_q == EMIT);
    assign word_data  = data_q;
    assign word_strb  = strb_q;
    assign word_addr  = addr_q;
    assign busy       = (state_q != FETCH) || (cnt_q != 3'd0);

endmodule

// File: tb/tb_uart_word_packer.sv
// Directed bench for uart_word_packer with a registered byte-FIFO model.
module tb_uart_word_packer;

    localparam logic [31:0] BASE = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic        fifo_r_en;
    logic [7:0]  fifo_data = 8'h00;
    logic        flush;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] word_data;
    logic [3:0]  word_strb;
    logic [31:0] word_addr;
    logic        busy;

    logic [7:0] mem [0:63];
    int wr_ptr  = 0;
    int rd_ptr  = 0;
    int ren_cnt = 0;
    int ren_bad = 0;
    int n_cmp   = 0;
    int n_bad   = 0;

    uart_word_packer #(
        .DATA_WIDTH    (8),
        .ADDR_WIDTH    (32),
        .BASE_ADDR     (BASE),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_r_en (fifo_r_en),
        .fifo_data (fifo_data),
        .flush     (flush),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .word_data (word_data),
        .word_strb (word_strb),
        .word_addr (word_addr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);

    // Byte FIFO model: data appears the cycle after an accepted read; reads while empty are logged.
    always @(posedge clk) begin
        if (fifo_r_en) begin
            ren_cnt <= ren_cnt + 1;
            if (fifo_empty) begin
                ren_bad <= ren_bad + 1;
            end else begin
                fifo_data <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (word_valid !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int ren0;
        int vseen;
        int stall_bad;

        rst        = 1'b1;
        flush      = 1'b0;
        word_ready = 1'b0;

        // Reset with bytes already waiting: nothing may be read while rst is high.
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        repeat (2) @(negedge clk);
        check_eq("rst_ren",   fifo_r_en,  0);
        check_eq("rst_valid", word_valid, 0);
        check_eq("rst_data",  word_data,  0);
        check_eq("rst_strb",  word_strb,  0);
        check_eq("rst_addr",  word_addr,  BASE);
        check_eq("rst_busy",  busy,       0);

        // Full word with the FIFO non-empty: first read at cycle 0, valid at cycle 8.
        rst        = 1'b0;
        word_ready = 1'b1;
        ren0       = ren_cnt;
        #1;
        check_eq("w1_first_ren", fifo_r_en, 1);
        wait_valid(20, n);
        check_eq("w1_latency", n,         8);
        check_eq("w1_data",    word_data, 32'h4433_2211);
        check_eq("w1_strb",    word_strb, 4'hF);
        check_eq("w1_addr",    word_addr, BASE);
        @(negedge clk);
        check_eq("w1_reads",   ren_cnt - ren0, 4);
        check_eq("w1_idle",    busy,           0);

        // Two bytes then idle: timeout of 10 emits the partial word at the next address.
        push(8'hAA); push(8'hBB);
        wait_valid(40, n);
        check_eq("to_latency", n,         15);
        check_eq("to_data",    word_data, 32'h0000_BBAA);
        check_eq("to_strb",    word_strb, 4'h3);
        check_eq("to_addr",    word_addr, 32'hFFFF_FFFC);
        @(negedge clk);

        // Three bytes then flush in FETCH: word next cycle, address wraps to zero.
        push(8'h01); push(8'h02); push(8'h03);
        repeat (6) @(negedge clk);
        check_eq("fl_busy_pre",  busy,       1);
        check_eq("fl_valid_pre", word_valid, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("fl_valid", word_valid, 1);
        check_eq("fl_data",  word_data,  32'h0003_0201);
        check_eq("fl_strb",  word_strb,  4'h7);
        check_eq("fl_addr",  word_addr,  32'h0000_0000);
        @(negedge clk);
        check_eq("fl_done", busy, 0);

        // Flush with nothing buffered must not produce a word.
        flush = 1'b1;
        vseen = 0;
        repeat (12) begin
            @(negedge clk);
            if (word_valid === 1'b1) vseen++;
        end
        flush = 1'b0;
        check_eq("fl_empty_words", vseen, 0);

        // Backpressure: word held stable for 50 cycles with no reads behind it.
        word_ready = 1'b0;
        push(8'h10); push(8'h11); push(8'h12); push(8'h13);
        push(8'h14); push(8'h15); push(8'h16); push(8'h17);
        wait_valid(30, n);
        check_eq("bp_latency", n,         8);
        check_eq("bp_data",    word_data, 32'h1312_1110);
        check_eq("bp_addr",    word_addr, 32'h0000_0004);
        ren0      = ren_cnt;
        stall_bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (word_valid !== 1'b1 || word_data !== 32'h1312_1110 ||
                word_addr !== 32'h0000_0004 || word_strb !== 4'hF) stall_bad++;
        end
        check_eq("bp_stable", stall_bad,      0);
        check_eq("bp_reads",  ren_cnt - ren0, 0);
        word_ready = 1'b1;
        @(negedge clk);
        wait_valid(30, n);
        check_eq("bp2_latency", n,         8);
        check_eq("bp2_data",    word_data, 32'h1716_1514);
        check_eq("bp2_addr",    word_addr, 32'h0000_0008);
        @(negedge clk);

        // Reset in WAIT on the second byte: state discarded, remaining bytes form a fresh word.
        push(8'h21); push(8'h22); push(8'h23); push(8'h24);
        repeat (3) @(negedge clk);
        check_eq("mr_busy_pre", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mr_ren",   fifo_r_en,  0);
        check_eq("mr_valid", word_valid, 0);
        check_eq("mr_data",  word_data,  0);
        check_eq("mr_strb",  word_strb,  0);
        check_eq("mr_addr",  word_addr,  BASE);
        check_eq("mr_busy",  busy,       0);
        push(8'h25); push(8'h26);
        rst = 1'b0;
        wait_valid(30, n);
        check_eq("mr_latency", n,         8);
        check_eq("mr_data2",   word_data, 32'h2625_2423);
        check_eq("mr_strb2",   word_strb, 4'hF);
        check_eq("mr_addr2",   word_addr, BASE);
        @(negedge clk);

        check_eq("ren_while_empty", ren_bad, 0);
        check_eq("bytes_drained",   rd_ptr,  23);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
